// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_sweep_ctrl
// Purpose  : Frequency sweep sequencer for a single-frequency test unit.
//            Steps a 14-bit frequency word from freq_start by freq_step for
//            n_points points, issues one unit_start per point, captures the
//            returned amplitude/phase into a result RAM and tracks the peak
//            amplitude. Results are read back through a registered port.
// Ports    : clk, rst (async, active-low)
//            sweep_start, abort, freq_start, freq_step, n_points  - control
//            unit_start, unit_freq, unit_done, unit_amp, unit_phase - unit i/f
//            busy, sweep_done, points_done, err, peak_amp, peak_idx - status
//            rd_addr, rd_amp, rd_phase                              - readback
// Revision : 1.0 - initial release
// ============================================================================
module freq_sweep_ctrl #(
   parameter int N_MAX       = 256,
   parameter int AW          = 8,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sweep_start,
   input  logic          abort,
   input  logic [13:0]   freq_start,
   input  logic [13:0]   freq_step,
   input  logic [AW:0]   n_points,
   output logic          unit_start,
   output logic [13:0]   unit_freq,
   input  logic          unit_done,
   input  logic [11:0]   unit_amp,
   input  logic [11:0]   unit_phase,
   output logic          busy,
   output logic          sweep_done,
   output logic [AW:0]   points_done,
   output logic          err,
   output logic [11:0]   peak_amp,
   output logic [AW-1:0] peak_idx,
   input  logic [AW-1:0] rd_addr,
   output logic [11:0]   rd_amp,
   output logic [11:0]   rd_phase
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_STORE     = 3'd3,
      S_GAP       = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   state_t        r_state;
   logic [13:0]   r_step;
   logic [AW:0]   r_npts;
   logic [AW:0]   r_idx;
   logic [14:0]   r_acc;     // running frequency; bit 14 flags range overflow
   logic [TW-1:0] r_tmo;
   logic [GW-1:0] r_gap;
   logic [11:0]   r_amp;
   logic [11:0]   r_phase;

   logic [23:0]   mem [N_MAX];

   logic [AW:0]   w_npts;
   logic          w_we;

   // Requests beyond the RAM depth are clamped when latched.
   assign w_npts = (n_points > (AW+1)'(N_MAX)) ? (AW+1)'(N_MAX) : n_points;
   // An abort in the STORE cycle discards the pending point.
   assign w_we   = (r_state == S_STORE) && !abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_npts      <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_tmo       <= '0;
         r_gap       <= '0;
         r_amp       <= '0;
         r_phase     <= '0;
         unit_start  <= 1'b0;
         unit_freq   <= '0;
         busy        <= 1'b0;
         sweep_done  <= 1'b0;
         points_done <= '0;
         err         <= 1'b0;
         peak_amp    <= '0;
         peak_idx    <= '0;
      end else begin
         unit_start <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (sweep_start) begin
                     r_acc       <= {1'b0, freq_start};
                     r_step      <= freq_step;
                     r_npts      <= w_npts;
                     r_idx       <= '0;
                     points_done <= '0;
                     err         <= 1'b0;
                     peak_amp    <= '0;
                     peak_idx    <= '0;
                     sweep_done  <= 1'b0;
                     busy        <= 1'b1;
                     r_state     <= (w_npts == '0) ? S_FINISH : S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  // Bit 14 set means the word is above 16383: end the sweep.
                  if (r_acc[14]) begin
                     r_state <= S_FINISH;
                  end else begin
                     unit_freq  <= r_acc[13:0];
                     unit_start <= 1'b1;
                     r_tmo      <= '0;
                     r_state    <= S_WAIT_DONE;
                  end
               end
               S_WAIT_DONE: begin
                  // unit_done is tested first so it wins over a same-cycle timeout.
                  if (unit_done) begin
                     r_amp   <= unit_amp;
                     r_phase <= unit_phase;
                     r_state <= S_STORE;
                  end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                     err     <= 1'b1;
                     r_amp   <= '0;
                     r_phase <= '0;
                     r_state <= S_STORE;
                  end else begin
                     r_tmo <= r_tmo + TW'(1);
                  end
               end
               S_STORE: begin
                  points_done <= points_done + (AW+1)'(1);
                  if (r_amp > peak_amp) begin
                     peak_amp <= r_amp;
                     peak_idx <= r_idx[AW-1:0];
                  end
                  r_idx   <= r_idx + (AW+1)'(1);
                  // Both operands are <= 16383, so the sum never exceeds 15 bits.
                  r_acc   <= r_acc + {1'b0, r_step};
                  r_gap   <= '0;
                  r_state <= ((r_idx + (AW+1)'(1)) == r_npts) ? S_FINISH : S_GAP;
               end
               S_GAP: begin
                  if (r_gap == GW'(GAP_CYC - 1)) begin
                     r_state <= S_ISSUE;
                  end else begin
                     r_gap <= r_gap + GW'(1);
                  end
               end
               S_FINISH: begin
                  sweep_done <= 1'b1;
                  busy       <= 1'b0;
                  r_state    <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Result storage: contents are not reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         mem[r_idx[AW-1:0]] <= {r_amp, r_phase};
      end
   end

   // Registered read; a same-address write in this cycle returns old data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_amp   <= '0;
         rd_phase <= '0;
      end else begin
         {rd_amp, rd_phase} <= mem[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_sweep_ctrl
// Purpose  : Self-checking bench for freq_sweep_ctrl. A behavioural test-unit
//            model answers unit_start pulses; expected frequencies and
//            results are queued when a sweep is launched and compared as the
//            DUT issues points and on readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_sweep_ctrl;

   localparam int N_MAX    = 256;
   localparam int AW       = 8;
   localparam int GAP_CYC  = 4;
   localparam int TMO      = 100;
   localparam int DONE_DLY = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          sweep_start, abort;
   logic [13:0]   freq_start, freq_step;
   logic [AW:0]   n_points;
   logic          unit_start;
   logic [13:0]   unit_freq;
   logic          unit_done;
   logic [11:0]   unit_amp, unit_phase;
   logic          busy, sweep_done, err;
   logic [AW:0]   points_done;
   logic [11:0]   peak_amp;
   logic [AW-1:0] peak_idx;
   logic [AW-1:0] rd_addr;
   logic [11:0]   rd_amp, rd_phase;

   freq_sweep_ctrl #(
      .N_MAX(N_MAX), .AW(AW), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .sweep_start(sweep_start), .abort(abort),
      .freq_start(freq_start), .freq_step(freq_step), .n_points(n_points),
      .unit_start(unit_start), .unit_freq(unit_freq), .unit_done(unit_done),
      .unit_amp(unit_amp), .unit_phase(unit_phase), .busy(busy),
      .sweep_done(sweep_done), .points_done(points_done), .err(err),
      .peak_amp(peak_amp), .peak_idx(peak_idx), .rd_addr(rd_addr),
      .rd_amp(rd_amp), .rd_phase(rd_phase)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit model configuration and scoreboard state.
   logic [11:0] amp_tbl   [N_MAX];
   logic [11:0] phase_tbl [N_MAX];
   int          no_resp    = -1;
   int          model_idx  = 0;
   int          start_cnt  = 0;
   int          start_base = 0;
   int          last_done  = 0;
   bit          have_done  = 0;
   int          wait_cyc;

   int          exp_freq [$];
   logic [23:0] exp_res  [$];
   int          exp_pts, exp_pk, exp_pki, exp_err;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Behavioural test unit: answers each start DONE_DLY cycles later.
   initial begin
      int f;
      unit_done = 1'b0; unit_amp = '0; unit_phase = '0;
      forever begin
         @(negedge clk);
         if (unit_start === 1'b1) begin
            start_cnt++;
            if (have_done)
               check_val("gap_after_done", 32'((cyc - last_done) >= GAP_CYC), 1);
            f = -1;
            if (exp_freq.size() == 0) check_val("extra_unit_start", 1, 0);
            else begin
               f = exp_freq.pop_front();
               check_val("unit_freq", 32'(unit_freq), f);
            end
            if (model_idx != no_resp) begin
               repeat (DONE_DLY - 1) @(negedge clk);
               unit_done  = 1'b1;
               unit_amp   = amp_tbl[model_idx];
               unit_phase = phase_tbl[model_idx];
               if (f >= 0) check_val("freq_hold", 32'(unit_freq), f);
               @(negedge clk);
               unit_done = 1'b0;
               last_done = cyc;
               have_done = 1;
            end
            model_idx++;
         end
      end
   end

   task automatic start_sweep(input int fs, input int st, input int np);
      int np_c, acc, a;
      logic [11:0] ph;
      np_c = (np > N_MAX) ? N_MAX : np;
      acc = fs; exp_pts = 0; exp_pk = 0; exp_pki = 0; exp_err = 0;
      for (int i = 0; i < np_c; i++) begin
         if (acc > 16383) break;
         exp_freq.push_back(acc);
         a  = (i == no_resp) ? 0 : int'(amp_tbl[i]);
         ph = (i == no_resp) ? 12'd0 : phase_tbl[i];
         exp_res.push_back({a[11:0], ph});
         if (a > exp_pk) begin exp_pk = a; exp_pki = i; end
         if (i == no_resp) exp_err = 1;
         exp_pts++;
         acc += st;
      end
      model_idx  = 0;
      have_done  = 0;
      start_base = start_cnt;
      freq_start = 14'(fs); freq_step = 14'(st); n_points = (AW+1)'(np);
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      check_val("busy_after_start", 32'(busy), 1);
   endtask

   task automatic finish_sweep();
      logic [23:0] e;
      wait_cyc = 1;
      for (int k = 0; k < 20000 && sweep_done !== 1'b1; k++) begin
         @(negedge clk);
         wait_cyc++;
      end
      check_val("sweep_done", 32'(sweep_done), 1);
      check_val("busy_at_end", 32'(busy), 0);
      check_val("points_done", 32'(points_done), exp_pts);
      check_val("start_count", start_cnt - start_base, exp_pts);
      check_val("peak_amp", 32'(peak_amp), exp_pk);
      check_val("peak_idx", 32'(peak_idx), exp_pki);
      check_val("err", 32'(err), exp_err);
      check_val("freq_queue_left", exp_freq.size(), 0);
      for (int i = 0; exp_res.size() > 0; i++) begin
         e = exp_res.pop_front();
         rd_addr = AW'(i);
         @(negedge clk);
         check_val("rd_amp", 32'(rd_amp), 32'(e[23:12]));
         check_val("rd_phase", 32'(rd_phase), 32'(e[11:0]));
      end
   endtask

   task automatic run_sweep(input int fs, input int st, input int np);
      start_sweep(fs, st, np);
      finish_sweep();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b0; sweep_start = 1'b0; abort = 1'b0;
      freq_start = '0; freq_step = '0; n_points = '0; rd_addr = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_sweep_done", 32'(sweep_done), 0);
      check_val("rst_unit_start", 32'(unit_start), 0);
      check_val("rst_unit_freq", 32'(unit_freq), 0);
      check_val("rst_points_done", 32'(points_done), 0);
      check_val("rst_peak_amp", 32'(peak_amp), 0);
      check_val("rst_rd_amp", 32'(rd_amp), 0);
      rst = 1'b1;
      @(negedge clk);

      // Nominal sweep
      for (int i = 0; i < 4; i++) begin amp_tbl[i] = 12'(10 * (i + 1)); phase_tbl[i] = 12'(i); end
      run_sweep(100, 50, 4);
      check_val("unit_freq_held", 32'(unit_freq), 250);

      // Frequency overflow ends the sweep early
      run_sweep(16300, 50, 5);

      // Timeout on idx 1
      amp_tbl[0] = 12'd5; amp_tbl[1] = 12'd99; amp_tbl[2] = 12'd9;
      phase_tbl[0] = 12'd1; phase_tbl[1] = 12'd2; phase_tbl[2] = 12'hF00;
      no_resp = 1;
      run_sweep(1000, 10, 3);
      no_resp = -1;

      // Zero points
      start_sweep(0, 0, 0);
      finish_sweep();
      check_val("zero_latency_ok", 32'(wait_cyc <= 3), 1);

      // Peak ties keep earliest index
      amp_tbl[0] = 12'd7; amp_tbl[1] = 12'd7; amp_tbl[2] = 12'd5;
      run_sweep(500, 1, 3);

      // Point count above N_MAX is clamped
      for (int i = 0; i < N_MAX; i++) begin
         amp_tbl[i] = 12'((i * 37 + 11) % 4096); phase_tbl[i] = 12'(i * 5);
      end
      run_sweep(0, 1, 300);

      // Abort during WAIT_DONE of idx 2
      start_sweep(200, 20, 5);
      for (int k = 0; k < 1000 && (start_cnt - start_base) < 3; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      check_val("abort_busy", 32'(busy), 0);
      check_val("abort_sweep_done", 32'(sweep_done), 0);
      check_val("abort_points_done", 32'(points_done), 2);
      abort = 1'b0;
      exp_freq.delete(); exp_res.delete();
      base = start_cnt;
      repeat (40) @(negedge clk);
      check_val("stray_done_busy", 32'(busy), 0);
      check_val("no_start_after_abort", start_cnt - base, 0);
      run_sweep(200, 20, 5);

      // Asynchronous reset in GAP
      start_sweep(100, 50, 4);
      for (int k = 0; k < 1000 && unit_done !== 1'b1; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 0);
      check_val("arst_points_done", 32'(points_done), 0);
      check_val("arst_unit_freq", 32'(unit_freq), 0);
      check_val("arst_peak_amp", 32'(peak_amp), 0);
      check_val("arst_rd_amp", 32'(rd_amp), 0);
      @(negedge clk);
      rst = 1'b1;
      exp_freq.delete(); exp_res.delete();
      base = start_cnt;
      repeat (60) @(negedge clk);
      check_val("no_start_after_rst", start_cnt - base, 0);
      check_val("idle_after_rst", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
- Sweep sequencer directly upstream of the single-frequency test unit.
- Steps a frequency word across a programmed range and issues one start pulse per point.
- Waits for the unit's done pulse, then captures amp/phase into an internal result RAM and tracks the peak-amplitude point.
- Host logic reads results back through a registered read port once sweep_done is set.

Parameters:
- N_MAX, 256, depth of result RAM and maximum number of points
- AW, 8, address width, clog2(N_MAX)
- GAP_CYC, 4, idle cycles between a captured done and the next unit_start; must be ≥2
- TIMEOUT_CYC, 50_000_000, cycles allowed for unit_done after unit_start before the point is marked failed

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sweep_start  in  1  one-cycle pulse; accepted only in IDLE
- abort  in  1  level; forces return to IDLE
- freq_start  in  14  first frequency word
- freq_step  in  14  increment per point, unsigned
- n_points  in  AW+1  requested point count, 0..N_MAX
- unit_start  out  1  one-cycle start pulse to the test unit
- unit_freq  out  14  frequency word to the test unit; held stable from unit_start until done
- unit_done  in  1  one-cycle done pulse from the test unit
- unit_amp  in  12  amplitude, valid with unit_done
- unit_phase  in  12  phase Q3.9 signed, valid with unit_done
- busy  out  1  high from accepted start until sweep_done or abort
- sweep_done  out  1  level; set at sweep end, cleared by the next accepted sweep_start
- points_done  out  AW+1  number of RAM entries written
- err  out  1  sticky; a timeout occurred this sweep
- peak_amp  out  12  largest amplitude captured
- peak_idx  out  AW  index of peak_amp
- rd_addr  in  AW  readback address
- rd_amp  out  12  RAM amplitude at rd_addr
- rd_phase  out  12  RAM phase at rd_addr

Behaviour:
- Reset values: all outputs 0; RAM contents are undefined. rd_* output 0 until the first read after reset.
- States: IDLE, ISSUE, WAIT_DONE, STORE, GAP, FINISH.
- IDLE, on sweep_start:
  - Latch freq_start, freq_step, n_points.
  - Clear idx, points_done, err, peak_amp, peak_idx and sweep_done.
  - busy goes to 1.
  - If n_points==0, go to FINISH; else go to ISSUE.
- ISSUE:
  - unit_freq = freq_start + idx*freq_step, computed as a 15-bit running accumulator (add freq_step per point; no multiplier).
  - If the accumulator exceeds 16383, go to FINISH without issuing.
  - Otherwise drive unit_start=1 for exactly one cycle, load the timeout counter, and go to WAIT_DONE.
- WAIT_DONE:
  - On unit_done, register amp/phase and go to STORE.
  - When the counter reaches TIMEOUT_CYC, set err, substitute amp=0 and phase=0, and go to STORE.
  - If unit_done and timeout coincide, unit_done wins.
- STORE (1 cycle):
  - Write {amp,phase} at idx and increment points_done.
  - If amp > peak_amp (strict), update peak_amp and peak_idx; ties keep the earliest index.
  - Increment idx.
  - If idx+1 == n_points, go to FINISH; else go to GAP.
- GAP:
  - Count GAP_CYC cycles, then go to ISSUE.
  - The gap guarantees the test unit is back in its start-wait state before the next start.
- FINISH (1 cycle): set sweep_done, clear busy, return to IDLE.
- Stray unit_done outside WAIT_DONE is ignored.
- sweep_start while busy is ignored.
- abort (any state except IDLE):
  - Next state is IDLE, busy=0, sweep_done stays 0.
  - points_done and RAM keep the entries already written.
  - unit_start is never asserted in the abort cycle.
- n_points > N_MAX is clamped to N_MAX at latch time.
- unit_freq changes only in ISSUE; it is held otherwise, including after the sweep.
- Read port: synchronous RAM read, 1-cycle latency (rd_addr at edge k gives data after edge k+1). Reads are legal at any time; read-during-write to the same address returns old data.
- Asynchronous reset mid-sweep returns to IDLE immediately with outputs at their reset values.

Test Plan:
- Nominal sweep: freq_start=100, freq_step=50, n_points=4, unit model done 20 cycles after start with amp=10*(idx+1), phase=idx.
  - unit_freq sequence 100,150,200,250.
  - Exactly 4 unit_start pulses, each ≥GAP_CYC cycles after the previous done.
  - points_done=4, peak_amp=40, peak_idx=3.
  - Readback at addr 2 gives 30/2 one cycle later.
- Overflow: freq_start=16300, freq_step=50, n_points=5 → 2 points issued (16300, 16350), points_done=2, sweep_done=1, err=0.
- Timeout: unit model never responds at idx 1, TIMEOUT_CYC reduced to 100 → RAM[1]=0/0, err=1, sweep continues, points_done=n_points.
- Zero/peak ties: n_points=0 → sweep_done within 3 cycles, no unit_start. Then n_points=3 with amps 7,7,5 → peak_idx=0.
- Abort: abort asserted in WAIT_DONE of idx 2 → IDLE next cycle, busy=0, sweep_done=0, points_done=2. A following sweep_start restarts from idx 0.
- Async reset: rst low mid-GAP → all outputs 0 without a clock edge; no unit_start after rst is released until a new sweep_start.
